// File: rtl/adc_tc_pkg.sv
// rtl/adc_tc_pkg.sv - shared types, defaults and burst-length lookup for adc_timing_ctrl
package adc_tc_pkg;

    typedef enum logic [1:0] {
        LANE_1    = 2'd0,
        LANE_2    = 2'd1,
        LANE_4    = 2'd2,
        LANE_RSVD = 2'd3
    } lane_code_t;

    localparam int DEF_PERIOD     = 24;
    localparam int DEF_T_CNVH     = 0;
    localparam int DEF_T_CNVL     = 3;
    localparam int DEF_T_CLKH     = 5;
    localparam int DEF_LATCH_DLY  = 2;
    localparam int DEF_LATCH_W    = 3;
    localparam int DEF_SYNC_PHASE = 0;
    localparam int MAX_N_CLK      = 9;

    // ceil(bits / (2 * lanes)); the reserved lane code behaves as a single lane
    function automatic logic [3:0] n_clk_lookup(input logic b18, input lane_code_t lc);
        logic [3:0] n;
        case (lc)
            LANE_2:  n = b18 ? 4'd5 : 4'd4;
            LANE_4:  n = b18 ? 4'd3 : 4'd2;
            default: n = b18 ? 4'd9 : 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/adc_tc_pulse.sv
// rtl/adc_tc_pulse.sv - registered pulse that rises at one frame phase and falls at another
module adc_tc_pulse #(
    parameter int PW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          sync,
    input  logic [PW-1:0] ph,
    input  logic [PW-1:0] set_ph,
    input  logic [PW-1:0] clr_ph,
    input  logic [PW-1:0] sync_ph,
    output logic          q
);

    // A realign keeps a running pulse only when its set phase is where the frame restarts
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            q <= 1'b0;
        end else if (sync) begin
            q <= q && (set_ph == sync_ph);
        end else if (ph == clr_ph) begin
            q <= 1'b0;
        end else if (ph == set_ph) begin
            q <= 1'b1;
        end
    end

endmodule

// File: rtl/adc_timing_ctrl.sv
// rtl/adc_timing_ctrl.sv - ADC conversion/clock/latch frame timing generator
// Optional sync phase checking is built when ADC_TC_SYNC_CHECK_EN is defined.
module adc_timing_ctrl
    import adc_tc_pkg::*;
#(
    parameter int PERIOD     = DEF_PERIOD,
    parameter int T_CNVH     = DEF_T_CNVH,
    parameter int T_CNVL     = DEF_T_CNVL,
    parameter int T_CLKH     = DEF_T_CLKH,
    parameter int LATCH_DLY  = DEF_LATCH_DLY,
    parameter int LATCH_W    = DEF_LATCH_W,
    parameter int SYNC_PHASE = DEF_SYNC_PHASE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync,
    input  logic       en,
    input  logic       bits_18,
    input  logic [1:0] lanes,
    input  logic       clr_err,
    output logic       cnv_en,
    output logic       clk_en,
    output logic       latch,
    output logic       frame_start,
    output logic       sync_err,
    output logic       cfg_err
);

    localparam int PW = $clog2(PERIOD);

    localparam logic [PW-1:0] PH_LAST  = PW'(PERIOD - 1);
    localparam logic [PW-1:0] SYNC_PH  = PW'(SYNC_PHASE);
    localparam logic [PW-1:0] CNVH_PH  = PW'(T_CNVH);
    localparam logic [PW-1:0] CNVL_PH  = PW'(T_CNVL);
    localparam logic [PW-1:0] CLKH_PH  = PW'(T_CLKH);
    localparam logic [PW-1:0] LDLY_PH  = PW'(LATCH_DLY);
    localparam logic [PW-1:0] LW_PH    = PW'(LATCH_W);

    generate
        if (PERIOD < 20 || PERIOD > 64) begin : g_bad_period
            $error("adc_timing_ctrl: PERIOD out of range 20..64");
        end
        if (T_CLKH + MAX_N_CLK + LATCH_DLY + LATCH_W > PERIOD - 1) begin : g_bad_latch
            $error("adc_timing_ctrl: clock burst plus latch does not fit in the frame");
        end
        if (T_CNVL <= T_CNVH) begin : g_bad_cnv
            $error("adc_timing_ctrl: T_CNVL must be after T_CNVH");
        end
    endgenerate

    logic [PW-1:0] ph;
    logic [PW-1:0] ph_next_free;
    logic          shadow_load;
    logic          sh_bits_18;
    lane_code_t    sh_lanes;
    logic [3:0]    n_clk;
    logic [PW-1:0] clk_clr_ph;
    logic [PW-1:0] latch_set_ph;
    logic [PW-1:0] latch_clr_ph;

    assign ph_next_free = (ph == PH_LAST) ? '0 : ph + 1'b1;
    assign shadow_load  = sync || (ph == PH_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            ph <= '0;
        end else if (sync) begin
            ph <= SYNC_PH;
        end else if (!en) begin
            ph <= '0;
        end else begin
            ph <= ph_next_free;
        end
    end

    // Configuration only takes effect at frame boundaries so a burst is never resized mid-frame
    always_ff @(posedge clk) begin
        if (rst || shadow_load) begin
            sh_bits_18 <= bits_18;
            sh_lanes   <= lane_code_t'(lanes);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else if (clr_err) begin
            cfg_err <= 1'b0;
        end else if (shadow_load && (lane_code_t'(lanes) == LANE_RSVD)) begin
            cfg_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= (ph == '0);
        end
    end

    assign n_clk        = n_clk_lookup(sh_bits_18, sh_lanes);
    assign clk_clr_ph   = CLKH_PH + {{(PW-4){1'b0}}, n_clk};
    assign latch_set_ph = clk_clr_ph + LDLY_PH;
    assign latch_clr_ph = latch_set_ph + LW_PH;

    adc_tc_pulse #(.PW(PW)) u_cnv (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .ph      (ph),
        .set_ph  (CNVH_PH),
        .clr_ph  (CNVL_PH),
        .sync_ph (SYNC_PH),
        .q       (cnv_en)
    );

    adc_tc_pulse #(.PW(PW)) u_clk (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .ph      (ph),
        .set_ph  (CLKH_PH),
        .clr_ph  (clk_clr_ph),
        .sync_ph (SYNC_PH),
        .q       (clk_en)
    );

    adc_tc_pulse #(.PW(PW)) u_latch (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .ph      (ph),
        .set_ph  (latch_set_ph),
        .clr_ph  (latch_clr_ph),
        .sync_ph (SYNC_PH),
        .q       (latch)
    );

`ifdef ADC_TC_SYNC_CHECK_EN
    // A sync that lands exactly where the free-running counter was headed is harmless
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err <= 1'b0;
        end else if (clr_err) begin
            sync_err <= 1'b0;
        end else if (sync && en && (ph_next_free != SYNC_PH)) begin
            sync_err <= 1'b1;
        end
    end
`else
    assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_timing_ctrl.sv
// tb/tb_adc_timing_ctrl.sv - randomized and directed bench for adc_timing_ctrl against a frame model
module tb_adc_timing_ctrl;

    localparam int PERIOD     = 24;
    localparam int T_CNVH     = 0;
    localparam int T_CNVL     = 3;
    localparam int T_CLKH     = 5;
    localparam int LATCH_DLY  = 2;
    localparam int LATCH_W    = 3;
    localparam int SYNC_PHASE = 0;

`ifdef ADC_TC_SYNC_CHECK_EN
    localparam int SYNC_CHK = 1;
`else
    localparam int SYNC_CHK = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sync = 1'b0;
    logic       en = 1'b0;
    logic       bits_18 = 1'b0;
    logic [1:0] lanes = 2'd0;
    logic       clr_err = 1'b0;
    logic       cnv_en, clk_en, latch, frame_start, sync_err, cfg_err;

    always #5 clk = ~clk;

    adc_timing_ctrl #(
        .PERIOD     (PERIOD),
        .T_CNVH     (T_CNVH),
        .T_CNVL     (T_CNVL),
        .T_CLKH     (T_CLKH),
        .LATCH_DLY  (LATCH_DLY),
        .LATCH_W    (LATCH_W),
        .SYNC_PHASE (SYNC_PHASE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sync        (sync),
        .en          (en),
        .bits_18     (bits_18),
        .lanes       (lanes),
        .clr_err     (clr_err),
        .cnv_en      (cnv_en),
        .clk_en      (clk_en),
        .latch       (latch),
        .frame_start (frame_start),
        .sync_err    (sync_err),
        .cfg_err     (cfg_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int m_ph = 0, m_b18 = 0, m_ln = 0;
    bit m_cnv, m_clk, m_latch, m_fs, m_serr, m_cfg;

    function automatic int nclk_of(input int b18, input int ln);
        int bits, nl;
        bits = b18 ? 18 : 16;
        nl   = (ln == 1) ? 2 : (ln == 2) ? 4 : 1;
        return (bits + 2 * nl - 1) / (2 * nl);
    endfunction

    function automatic bit in_win(input int p, input int s, input int c);
        return (p >= s) && (p < c);
    endfunction

    task automatic model_step();
        int n, cclr, lset, nfree;
        bit load;
        if (rst) begin
            m_ph = 0; m_b18 = int'(bits_18); m_ln = int'(lanes);
            {m_cnv, m_clk, m_latch, m_fs, m_serr, m_cfg} = '0;
        end else begin
            n     = nclk_of(m_b18, m_ln);
            cclr  = T_CLKH + n;
            lset  = cclr + LATCH_DLY;
            nfree = (m_ph == PERIOD - 1) ? 0 : m_ph + 1;
            load  = sync || (m_ph == PERIOD - 1);
            if (!en) begin
                {m_cnv, m_clk, m_latch, m_fs} = '0;
            end else if (sync) begin
                m_cnv   = m_cnv && (T_CNVH == SYNC_PHASE);
                m_clk   = m_clk && (T_CLKH == SYNC_PHASE);
                m_latch = m_latch && (lset == SYNC_PHASE);
                m_fs    = (m_ph == 0);
            end else begin
                m_cnv   = in_win(m_ph, T_CNVH, T_CNVL);
                m_clk   = in_win(m_ph, T_CLKH, cclr);
                m_latch = in_win(m_ph, lset, lset + LATCH_W);
                m_fs    = (m_ph == 0);
            end
            if (SYNC_CHK != 0) begin
                if (clr_err) m_serr = 1'b0;
                else if (sync && en && nfree != SYNC_PHASE) m_serr = 1'b1;
            end
            if (clr_err) m_cfg = 1'b0;
            else if (load && lanes == 2'd3) m_cfg = 1'b1;
            if (load) begin
                m_b18 = int'(bits_18);
                m_ln  = int'(lanes);
            end
            if (sync) m_ph = SYNC_PHASE;
            else if (!en) m_ph = 0;
            else m_ph = nfree;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("cnv_en", cnv_en, m_cnv);
        check("clk_en", clk_en, m_clk);
        check("latch", latch, m_latch);
        check("frame_start", frame_start, m_fs);
        check("sync_err", sync_err, m_serr);
        check("cfg_err", cfg_err, m_cfg);
    endtask

    task automatic do_reset(input logic b, input logic [1:0] l);
        rst = 1'b1; bits_18 = b; lanes = l; sync = 1'b0; clr_err = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int c_cnv, c_clk, c_latch, c_fs, c_a, c_b, first_latch;

        // reset state
        en = 1'b1;
        do_reset(1'b0, 2'd1);
        check("rst_outs", {cnv_en, clk_en, latch, frame_start, sync_err, cfg_err}, 0);

        // 16-bit, 2 lanes, two full frames
        c_cnv = 0; c_clk = 0; c_latch = 0; c_fs = 0; first_latch = -1;
        for (int i = 1; i <= 48; i++) begin
            tick();
            c_cnv += cnv_en; c_clk += clk_en; c_latch += latch; c_fs += frame_start;
            if (latch && first_latch < 0) first_latch = i;
        end
        check("d16x2_cnv_cnt", c_cnv, 6);
        check("d16x2_clk_cnt", c_clk, 8);
        check("d16x2_latch_cnt", c_latch, 6);
        check("d16x2_fs_cnt", c_fs, 2);
        check("d16x2_latch_first", first_latch, 12);

        // 18-bit 1 lane, switch to 4 lanes mid-frame
        do_reset(1'b1, 2'd0);
        c_a = 0; c_b = 0;
        for (int i = 1; i <= 48; i++) begin
            if (i == 8) lanes = 2'd2;
            tick();
            if (i <= 24) c_a += clk_en; else c_b += clk_en;
        end
        check("d18_clk_frame1", c_a, 9);
        check("d18_clk_frame2", c_b, 3);

        // reserved lane code
        do_reset(1'b0, 2'd0);
        lanes = 2'd3;
        c_b = 0;
        for (int i = 1; i <= 48; i++) begin
            tick();
            if (i == 23) check("rsvd_cfg_before", cfg_err, 0);
            if (i == 24) check("rsvd_cfg_after", cfg_err, 1);
            if (i > 24) c_b += clk_en;
        end
        check("rsvd_clk_cnt", c_b, 8);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("rsvd_cfg_clr", cfg_err, 0);
        lanes = 2'd0;

        // sync mid-frame and at frame end
        do_reset(1'b0, 2'd0);
        for (int i = 0; i < 10; i++) tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        check("sync_mid_err", sync_err, SYNC_CHK);
        tick();
        check("sync_mid_realign", frame_start, 1);
        do_reset(1'b0, 2'd0);
        for (int i = 0; i < 23; i++) tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        check("sync_end_err", sync_err, 0);

        // en drop during clk_en, reset during latch
        do_reset(1'b0, 2'd1);
        for (int i = 0; i < 6; i++) tick();
        check("endrop_clk_before", clk_en, 1);
        en = 1'b0;
        tick();
        check("endrop_clk_after", clk_en, 0);
        en = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("rstmid_latch_before", latch, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_outs", {cnv_en, clk_en, latch, frame_start}, 0);
        tick();
        check("rstmid_ph0", frame_start, 1);

        // randomized traffic against the model
        do_reset(1'b0, 2'd0);
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 299) == 0);
            sync    = ($urandom_range(0, 39) == 0);
            clr_err = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 19) == 0) begin
                bits_18 = 1'($urandom_range(0, 1));
                lanes   = 2'($urandom_range(0, 3));
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_timing_ctrl.md
ADC_TIMING_CTRL -- requirements
Module: adc_timing_ctrl

Interface
REQ-001 SHALL have parameter PERIOD, default 24: fast-clock cycles per conversion frame (range 20..64).
REQ-002 SHALL have parameter T_CNVH, default 0: frame phase at which cnv_en is set.
REQ-003 SHALL have parameter T_CNVL, default 3: frame phase at which cnv_en is cleared.
REQ-004 SHALL have parameter T_CLKH, default 5: frame phase at which clk_en is set.
REQ-005 SHALL have parameter LATCH_DLY, default 2: cycles from clk_en clear to latch set.
REQ-006 SHALL have parameter LATCH_W, default 3: latch high width in cycles.
REQ-007 SHALL have parameter SYNC_PHASE, default 0: phase loaded when sync is high.
REQ-008 SHALL have port clk  in  1  high-speed master clock; one clock; reset is synchronous and active-high.
REQ-009 SHALL have port rst  in  1  synchronous active-high reset.
REQ-010 SHALL have port sync  in  1  phase realign request.
REQ-011 SHALL have port en  in  1  run enable; low forces outputs low.
REQ-012 SHALL have port bits_18  in  1  1=18-bit ADC, 0=16-bit.
REQ-013 SHALL have port lanes  in  2  0=1 lane, 1=2 lanes, 2=4 lanes, 3=reserved.
REQ-014 SHALL have port clr_err  in  1  clears sticky error flags.
REQ-015 SHALL have ports cnv_en, clk_en, latch, frame_start  out  1 each; sync_err, cfg_err  out  1 each.

Function
REQ-016 SHALL keep phase counter ph of width clog2(PERIOD): sync -> ph<=SYNC_PHASE; else ph==PERIOD-1 -> 0; else ph+1; en=0 and no sync -> ph<=0.
REQ-017 SHALL sample bits_18/lanes into shadow registers only on rst, on sync, or when ph==PERIOD-1; mid-frame input changes have no effect until then.
REQ-018 SHALL derive burst length N_CLK=ceil(bits/(2*lanes)) from shadows: 16-bit 8/4/2, 18-bit 9/5/3 for 1/2/4 lanes.
REQ-019 SHALL treat lanes=3 as 1 lane and set sticky cfg_err on the shadow load that captures it.
REQ-020 SHALL register all outputs: a phase match at edge k changes the output after edge k (one-cycle latency).
REQ-021 SHALL set cnv_en at ph==T_CNVH, clear at ph==T_CNVL.
REQ-022 SHALL set clk_en at ph==T_CLKH, clear at ph==T_CLKH+N_CLK (exactly N_CLK cycles high).
REQ-023 SHALL set latch at ph==T_CLKH+N_CLK+LATCH_DLY, clear LATCH_W cycles later.
REQ-024 SHALL pulse frame_start for one cycle when ph==0 and en=1.
REQ-025 SHALL, with en=0, drive cnv_en/clk_en/latch/frame_start low on the next cycle, truncating any active pulse; on en rising, frame begins at ph 0.
REQ-026 SHALL, on sync during an active pulse, clear that pulse unless its set phase equals SYNC_PHASE.
REQ-027 SHALL give clr_err priority below rst and above a same-cycle error set (set wins next cycle only if condition persists).
REQ-028 SHALL fail elaboration if T_CLKH+9+LATCH_DLY+LATCH_W > PERIOD-1 or T_CNVL <= T_CNVH.

Reset
REQ-029 SHALL on rst set ph=0, all outputs 0, errors 0, shadows loaded from current bits_18/lanes; rst overrides sync and en.

Configuration
REQ-030 SHALL, with ADC_TC_SYNC_CHECK_EN defined, set sticky sync_err when sync arrives with en=1 and the next free-running ph would not equal SYNC_PHASE.
REQ-031 SHALL, without ADC_TC_SYNC_CHECK_EN, tie sync_err to 0 and include no check logic.

Structure
REQ-032 SHALL place lane-code enum, N_CLK lookup function and defaults in package adc_tc_pkg.
REQ-033 SHALL instantiate sub-module adc_tc_pulse (set-phase/clear-phase registered pulse) for cnv_en, clk_en and latch.

Verification
REQ-034 Defaults, 16-bit, 2 lanes, en=1 -> clk_en high 4 cycles per 24, latch high phases 12..14 +1 latency, cnv_en high 3 cycles.
REQ-035 18-bit, 1 lane -> clk_en 9 cycles; switch to 4 lanes at ph 7 -> current frame 9, next frame 3.
REQ-036 lanes=3 -> cfg_err=1 after frame boundary, clk_en 8 cycles (16-bit); clr_err -> cfg_err=0.
REQ-037 sync at ph 10 with SYNC_PHASE=0 (macro on) -> ph=0 next, sync_err=1; sync at ph 23 -> sync_err stays 0; macro off -> sync_err always 0.
REQ-038 en dropped while clk_en high -> clk_en low next cycle; rst mid-latch -> all outputs 0 next cycle, ph=0.
